// File: rtl/dcache_sram_bank.sv
// ============================================================================
// Module   : dcache_sram_bank
// Brief    : Byte-lane-writable data-cache SRAM bank with a one-word-per-cycle
//            clear sweep and an optional read output register. Defining
//            DCACHE_SRAM_BYPASS_EN forwards same-cycle write bytes to reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_sram_bank #(
    parameter  int ADDR_WIDTH = 9,
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_SIZE  = 8,
    parameter  int OUTPUT_REG = 0,
    localparam int BE_WIDTH   = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int                  c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_busy;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_next;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    assign w_busy   = (r_state == CLEAR);
    assign busy     = w_busy;
    assign w_wr_acc = wr_en & ~w_busy;
    assign w_rd_acc = rd_en & ~w_busy;

    // Sweep control: clr_req is only honoured from IDLE, so it cannot restart a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_cnt == c_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_cnt <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; contents are only ever zeroed by the sweep.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_byte_en[i]) begin
                    r_mem[wr_addr][i*BYTE_SIZE +: BYTE_SIZE] <= wr_data[i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    assign w_rd_word = r_mem[rd_addr];

`ifdef DCACHE_SRAM_BYPASS_EN
    logic w_fwd_hit;
    assign w_fwd_hit = w_wr_acc && (wr_addr == rd_addr);

    for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
        assign w_rd_next[g*BYTE_SIZE +: BYTE_SIZE] = (w_fwd_hit && wr_byte_en[g]) ?
            wr_data[g*BYTE_SIZE +: BYTE_SIZE] : w_rd_word[g*BYTE_SIZE +: BYTE_SIZE];
    end
`else
    assign w_rd_next = w_rd_word;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_next;
            end
        end
    end

    if (OUTPUT_REG == 1) begin : g_out_reg
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rd_valid = r_s2_valid;
        assign rd_data  = r_s2_data;
    end else begin : g_no_out_reg
        assign rd_valid = r_s1_valid;
        assign rd_data  = r_s1_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_sram_bank.sv
// ============================================================================
// Module   : tb_dcache_sram_bank
// Brief    : Scoreboard bench driving one OUTPUT_REG=0 and one OUTPUT_REG=1
//            bank with identical directed traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_sram_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic        busy0, busy1;
    logic        rd_valid0, rd_valid1;
    logic [31:0] rd_data0, rd_data1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_sram_bank #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_SIZE(8), .OUTPUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    dcache_sram_bank #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_SIZE(8), .OUTPUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every rd_valid pops one expectation and checks data and arrival cycle.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n) begin
            if (rd_valid0) begin
                if (q0.size() == 0) begin
                    chk("rd_valid_unexpected_r0", 32'(rd_valid0), 32'd0);
                end else begin
                    e = q0.pop_front();
                    chk("rd_data_r0", rd_data0, e.data);
                    chk("rd_latency_r0", 32'(cyc), 32'(e.due));
                end
            end else if (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front();
                chk("rd_valid_missing_r0", 32'(rd_valid0), 32'd1);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n) begin
            if (rd_valid1) begin
                if (q1.size() == 0) begin
                    chk("rd_valid_unexpected_r1", 32'(rd_valid1), 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("rd_data_r1", rd_data1, e.data);
                    chk("rd_latency_r1", 32'(cyc), 32'(e.due));
                end
            end else if (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                chk("rd_valid_missing_r1", 32'(rd_valid1), 32'd1);
            end
        end
    end

    // One clock of stimulus; a read pushes its expected word for both banks.
    task automatic op(input logic clr, input logic we, input logic [8:0] wa,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic re, input logic [8:0] ra, input logic [31:0] rexp);
        @(posedge clk);
        #1;
        clr_req    = clr;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        wr_byte_en = be;
        rd_en      = re;
        rd_addr    = ra;
        if (re) begin
            q0.push_back('{rexp, cyc + 1});
            q1.push_back('{rexp, cyc + 2});
        end
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0, 32'h0);
    endtask

    // Counts busy cycles; optionally injects an ignored write+read, a clr_req, or a reset.
    task automatic sweep(input int wr_at, input int clr_at, input int rst_at, output int n);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!busy0) break;
            n++;
            if (n == wr_at)      begin wr_en = 1'b1; wr_addr = 9'h002; wr_data = 32'hFFFFFFFF;
                                       wr_byte_en = 4'hF; rd_en = 1'b1; rd_addr = 9'h002; end
            if (n == wr_at + 1)  begin wr_en = 1'b0; rd_en = 1'b0; end
            if (n == clr_at)     clr_req = 1'b1;
            if (n == clr_at + 1) clr_req = 1'b0;
            if (n == rst_at)     begin rst_n = 1'b0; break; end
        end
        if (n >= 1000) chk("sweep_timeout", 32'(busy0), 32'd0);
    endtask

    task automatic chk_reset_state();
        chk("reset_busy_r0", 32'(busy0), 32'd1);
        chk("reset_busy_r1", 32'(busy1), 32'd1);
        chk("reset_rd_valid_r0", 32'(rd_valid0), 32'd0);
        chk("reset_rd_valid_r1", 32'(rd_valid1), 32'd0);
        chk("reset_rd_data_r0", rd_data0, 32'h0);
        chk("reset_rd_data_r1", rd_data1, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          n;
        logic [31:0] byp_exp;
        rst_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_byte_en = '0; rd_en = 1'b0; rd_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state();

        // Initial sweep after reset release: exactly 512 busy cycles.
        @(posedge clk); #1; rst_n = 1'b1;
        sweep(-10, -10, -10, n);
        chk("busy_cycles_initial", 32'(n), 32'd512);
        chk("busy_after_sweep_r1", 32'(busy1), 32'd0);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h1FF, 32'h00000000);

        // Byte-lane merge and zero-enable write.
        op(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 4'b1111, 1'b0, 9'h0, 32'h0);
        op(1'b0, 1'b1, 9'h005, 32'h11223344, 4'b0101, 1'b0, 9'h0, 32'h0);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h005, 32'hDE22BE44);
        op(1'b0, 1'b1, 9'h005, 32'hFFFFFFFF, 4'b0000, 1'b0, 9'h0, 32'h0);
        op(1'b0, 1'b1, 9'h006, 32'hAABBCCDD, 4'b1000, 1'b1, 9'h005, 32'hDE22BE44);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h006, 32'hAA000000);

        // Same-cycle write and read of one address.
`ifdef DCACHE_SRAM_BYPASS_EN
        byp_exp = 32'hCAFEF00D;
`else
        byp_exp = 32'h00000000;
`endif
        op(1'b0, 1'b1, 9'h010, 32'hCAFEF00D, 4'b1111, 1'b1, 9'h010, byp_exp);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h010, 32'hCAFEF00D);

        // Back-to-back reads of 1,2,3.
        op(1'b0, 1'b1, 9'h001, 32'h11111111, 4'hF, 1'b0, 9'h0, 32'h0);
        op(1'b0, 1'b1, 9'h002, 32'h22222222, 4'hF, 1'b0, 9'h0, 32'h0);
        op(1'b0, 1'b1, 9'h003, 32'h33333333, 4'hF, 1'b0, 9'h0, 32'h0);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h001, 32'h11111111);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h002, 32'h22222222);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h003, 32'h33333333);
        idle();
        idle();

        // clr_req with a same-cycle read (old data), then an ignored write and a second clr_req.
        op(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h005, 32'hDE22BE44);
        idle();
        sweep(50, 100, -10, n);
        chk("busy_cycles_clr_ignored", 32'(n), 32'd512);
        chk("rd_data_hold_r0", rd_data0, 32'hDE22BE44);
        chk("rd_data_hold_r1", rd_data1, 32'hDE22BE44);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h002, 32'h00000000);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h005, 32'h00000000);
        idle();
        idle();

        // Reset in the middle of a sweep restarts it from word 0.
        op(1'b0, 1'b1, 9'h007, 32'h77777777, 4'hF, 1'b0, 9'h0, 32'h0);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h007, 32'h77777777);
        op(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0, 32'h0);
        idle();
        sweep(-10, -10, 300, n);
        chk("sweep_words_before_reset", 32'(n), 32'd300);
        repeat (2) @(negedge clk);
        chk_reset_state();
        @(posedge clk); #1; rst_n = 1'b1;
        sweep(-10, -10, -10, n);
        chk("busy_cycles_after_reset", 32'(n), 32'd512);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h007, 32'h00000000);
        op(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h1FF, 32'h00000000);
        idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained_r0", 32'(q0.size()), 32'd0);
        chk("scoreboard_drained_r1", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_sram_bank.md
DCACHE_SRAM_BANK -- requirements
Module: dcache_sram_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, address bits; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of BYTE_SIZE.
REQ-003 Parameter BYTE_SIZE, default 8, bits per byte lane (legal values 8 or 9).
REQ-004 Parameter OUTPUT_REG, default 0, adds one read output register stage when set to 1.
REQ-005 Derived localparam BE_WIDTH = DATA_WIDTH/BYTE_SIZE; it is not overridable.
REQ-006 Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 clr_req  input  1  single-cycle request to zero the whole array.
REQ-010 busy  output  1  high while a clear sweep is running.
REQ-011 wr_en  input  1  write strobe.
REQ-012 wr_addr  input  ADDR_WIDTH  write word address.
REQ-013 wr_data  input  DATA_WIDTH  write data.
REQ-014 wr_byte_en  input  BE_WIDTH  per-lane write enable; bit i covers bits [i*BYTE_SIZE +: BYTE_SIZE].
REQ-015 rd_en  input  1  read strobe.
REQ-016 rd_addr  input  ADDR_WIDTH  read word address.
REQ-017 rd_data  output  DATA_WIDTH  read data.
REQ-018 rd_valid  output  1  one-cycle pulse, aligned with rd_data, for each accepted read.

Function
REQ-019 The FSM SHALL have exactly two states: CLEAR and IDLE.
REQ-020 In CLEAR, one word per cycle SHALL be written to zero, with a counter running 0 to 2**ADDR_WIDTH-1; after the last word the FSM SHALL enter IDLE on the next cycle; busy SHALL be 1 exactly while in CLEAR.
REQ-021 clr_req in IDLE SHALL enter CLEAR on the next cycle with the counter at 0; clr_req during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-022 While busy=1, wr_en and rd_en SHALL be ignored: no array update and no rd_valid.
REQ-023 An accepted write (wr_en=1, busy=0) SHALL update only the lanes whose wr_byte_en bit is set; wr_byte_en=0 SHALL leave the word unchanged.
REQ-024 Read latency from the rd_en edge to rd_valid/rd_data SHALL be 1 cycle when OUTPUT_REG=0 and 2 cycles when OUTPUT_REG=1; back-to-back reads SHALL be accepted every cycle.
REQ-025 rd_data SHALL hold its last value when no read completes.
REQ-026 A read whose address matches a same-cycle accepted write SHALL behave as defined in REQ-031/REQ-032.
REQ-027 Reads accepted before a clr_req SHALL complete normally; a read accepted in the cycle clr_req is sampled in IDLE SHALL return pre-clear contents.
REQ-028 Address counters and addresses SHALL NOT wrap beyond depth; there is no out-of-range address.

Reset
REQ-029 On rst_n low: FSM SHALL be in CLEAR with the counter at 0, busy SHALL be 1, rd_valid SHALL be 0, rd_data SHALL be 0, and all pipeline stages SHALL be empty. Array contents SHALL NOT be reset directly.
REQ-030 On rst_n release, the sweep SHALL start from address 0; a reset asserted mid-sweep SHALL restart the sweep from 0.

Configuration
REQ-031 With macro DCACHE_SRAM_BYPASS_EN defined, a same-address read-during-write SHALL return the merged word: new bytes on enabled lanes, old bytes elsewhere.
REQ-032 Without DCACHE_SRAM_BYPASS_EN, a same-address read-during-write SHALL return the old word; no forwarding logic SHALL be synthesised.

Verification (ADDR_WIDTH=9, DATA_WIDTH=32, OUTPUT_REG=0 unless stated)
REQ-033 Release reset -> busy=1 for exactly 512 cycles, then 0; a read of address 0x1FF -> 0x00000000, rd_valid after 1 cycle.
REQ-034 Write 0xDEADBEEF to 0x005 with be=4'b1111, then write 0x11223344 with be=4'b0101 -> a read of 0x005 returns 0xDE22BE44.
REQ-035 Same-cycle write of 0xCAFEF00D (be=4'b1111) and read of 0x010, which holds 0 -> 0xCAFEF00D with BYPASS_EN defined, 0x00000000 without.
REQ-036 OUTPUT_REG=1, reads of addresses 1,2,3 on consecutive cycles -> rd_valid high 2 cycles after each, returning the data in the same order.
REQ-037 Write during busy, then clr_req at sweep word 100, then rst_n low at word 300 -> no write takes effect, the sweep is not restarted by clr_req, and it restarts at 0 after reset with busy=1 for 512 cycles.
